facial_detection_sequencer: RTL and testbench
=============================================

FACIAL_DETECTION_SEQUENCER -- requirements
Module: facial_detection_sequencer

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 16: width of the pixel bus on both the host side and the IP side.
REQ-002 SHALL have parameter DATA_WIDTH_12, default 12: width of the result data bus.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: watchdog limit in cycles.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i_frame_start, input, 1 bit: host request to process one frame.
REQ-007 SHALL have port i_pixel_valid, input, 1 bit; port i_pixel, input, PIXEL_WIDTH bits; port o_pixel_ready, output, 1 bit: host pixel stream.
REQ-008 SHALL have port o_ip_reset, output, 1 bit: active-high reset pulse to the detection IP.
REQ-009 SHALL have port o_start_recieve_pixel, output, 1 bit; port o_pixel, output, PIXEL_WIDTH bits; port o_end_recieve_pixel, output, 1 bit: pixel transfer to the IP.
REQ-010 SHALL have port i_ready_recieve_pixel, input, 1 bit; port i_end_frame, input, 1 bit: IP pixel acknowledge and end-of-frame.
REQ-011 SHALL have port o_enable_read_result, output, 1 bit; port i_result_data, input, DATA_WIDTH_12 bits; port i_result_end, input, 1 bit: IP result read.
REQ-012 SHALL have port o_result_valid, output, 1 bit; port o_result_data, output, DATA_WIDTH_12 bits; port i_result_ready, input, 1 bit: host result stream.
REQ-013 SHALL have port o_busy, output, 1 bit; port o_frame_done, output, 1 bit; port o_error, output, 1 bit; port o_result_count, output, 16 bits: status.

Function
REQ-014 SHALL implement FSM states IDLE, IP_RESET, SEND_PIXEL, WAIT_ACK, READ_RESULT, DONE, ERROR; all outputs SHALL be registered.
REQ-015 SHALL, in IDLE with i_frame_start=1, go to IP_RESET; in every other state except ERROR, i_frame_start SHALL be ignored.
REQ-016 SHALL assert o_ip_reset for exactly one cycle while in IP_RESET, clear o_result_count, then go to SEND_PIXEL.
REQ-017 SHALL drive o_pixel_ready=1 only in SEND_PIXEL; i_pixel_valid&&o_pixel_ready SHALL latch i_pixel into o_pixel, pulse o_start_recieve_pixel for the next single cycle, and go to WAIT_ACK.
REQ-018 SHALL hold o_end_recieve_pixel=1 throughout WAIT_ACK; when i_ready_recieve_pixel=1 is sampled, it SHALL return to SEND_PIXEL with o_end_recieve_pixel=0.
REQ-019 SHALL, when i_end_frame=1 in SEND_PIXEL or WAIT_ACK, go to READ_RESULT; end_frame has priority over a simultaneous pixel accept, and no pixel SHALL be accepted in that cycle.
REQ-020 SHALL, in READ_RESULT, pulse o_enable_read_result for one cycle only when o_result_valid=0 and no read is outstanding.
REQ-021 SHALL capture i_result_data into o_result_data on the cycle after the enable pulse, set o_result_valid, and increment o_result_count, saturating at 16'hFFFF.
REQ-022 SHALL hold o_result_valid and o_result_data stable until i_result_ready=1, then clear o_result_valid (single-entry buffer).
REQ-023 SHALL, on i_result_end=1 in READ_RESULT, go to DONE only when o_result_valid=0 and no read is outstanding; otherwise it SHALL remember result_end and exit once the buffer drains.
REQ-024 SHALL, in DONE, pulse o_frame_done for one cycle, then go to IDLE.
REQ-025 SHALL drive o_busy=1 in every state except IDLE and ERROR.

Reset
REQ-026 SHALL, while reset_n=0, force state IDLE and all outputs to 0, regardless of the state reset_n arrives in; o_pixel, o_result_data and o_result_count SHALL also be cleared to 0.
REQ-027 SHALL be fully operational from the first clock edge after reset_n is deasserted.

Configuration
REQ-028 SHALL include the watchdog only when FDS_TIMEOUT_EN is defined.
REQ-029 SHALL, when FDS_TIMEOUT_EN is defined, count consecutive cycles in WAIT_ACK, or in READ_RESULT without a capture; the count SHALL reset on state change or capture.
REQ-030 SHALL, when that count reaches TIMEOUT_CYCLES, go to ERROR and set o_error sticky.
REQ-031 SHALL, in ERROR, on i_frame_start=1, clear o_error and go to IP_RESET.
REQ-032 SHALL, without FDS_TIMEOUT_EN, tie o_error to 0, leave ERROR unreachable, and contain no counter logic.

Verification
REQ-033 SHALL cover: i_frame_start pulse from IDLE -> o_ip_reset=1 for exactly 1 cycle, o_busy=1, o_pixel_ready=1 on the following cycle.
REQ-034 SHALL cover: i_pixel=16'h00A5 accepted, i_ready_recieve_pixel delayed 5 cycles -> o_start_recieve_pixel 1-cycle pulse with o_pixel=16'h00A5, o_end_recieve_pixel high for 5 cycles, then o_pixel_ready=1.
REQ-035 SHALL cover: i_end_frame and i_pixel_valid asserted in the same SEND_PIXEL cycle -> state READ_RESULT, pixel not latched, o_pixel unchanged.
REQ-036 SHALL cover: 3 results 12'h010/12'h020/12'h030 with i_result_ready held low 4 cycles each -> data delivered in order, no loss, o_result_count=3, i_result_end -> o_frame_done 1-cycle pulse, o_busy=0.
REQ-037 SHALL cover, with FDS_TIMEOUT_EN and TIMEOUT_CYCLES=16: i_ready_recieve_pixel never asserted -> o_error=1 after 16 WAIT_ACK cycles; i_frame_start -> o_error=0 and an o_ip_reset pulse.
REQ-038 SHALL cover: reset_n driven low mid-READ_RESULT with o_result_valid=1 -> all outputs 0 immediately, without waiting for a clock edge, and state IDLE.

Source files
------------

// File: rtl/facial_detection_sequencer.sv
// Frame sequencer between a host pixel/result stream and a face-detection IP core.
// Define FDS_TIMEOUT_EN to build in the WAIT_ACK / READ_RESULT watchdog and the ERROR state.
module facial_detection_sequencer #(
  parameter int PIXEL_WIDTH    = 16,
  parameter int DATA_WIDTH_12  = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_frame_start,
  input  logic                     i_pixel_valid,
  input  logic [PIXEL_WIDTH-1:0]   i_pixel,
  output logic                     o_pixel_ready,
  output logic                     o_ip_reset,
  output logic                     o_start_recieve_pixel,
  output logic [PIXEL_WIDTH-1:0]   o_pixel,
  output logic                     o_end_recieve_pixel,
  input  logic                     i_ready_recieve_pixel,
  input  logic                     i_end_frame,
  output logic                     o_enable_read_result,
  input  logic [DATA_WIDTH_12-1:0] i_result_data,
  input  logic                     i_result_end,
  output logic                     o_result_valid,
  output logic [DATA_WIDTH_12-1:0] o_result_data,
  input  logic                     i_result_ready,
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic                     o_error,
  output logic [15:0]              o_result_count
);

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_IP_RESET    = 3'd1;
  localparam logic [2:0] ST_SEND_PIXEL  = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK    = 3'd3;
  localparam logic [2:0] ST_READ_RESULT = 3'd4;
  localparam logic [2:0] ST_DONE        = 3'd5;
  localparam logic [2:0] ST_ERROR       = 3'd6;

  logic [2:0]               state_q, state_d;
  logic                     pixel_ready_q, pixel_ready_d;
  logic                     ip_reset_q, ip_reset_d;
  logic                     start_q, start_d;
  logic                     end_q, end_d;
  logic                     enable_q, enable_d;
  logic                     rd_wait_q, rd_wait_d;
  logic                     result_valid_q, result_valid_d;
  logic                     busy_q, busy_d;
  logic                     frame_done_q, frame_done_d;
  logic                     end_seen_q, end_seen_d;
  logic [PIXEL_WIDTH-1:0]   pixel_q, pixel_d;
  logic [DATA_WIDTH_12-1:0] result_data_q, result_data_d;
  logic [15:0]              count_q, count_d;

  logic accept;
  logic capture;
  logic outstanding;
  logic result_end_any;
  logic timeout;

  // The IP answers a read enable one cycle later, so a read spans the pulse cycle plus one.
  assign outstanding    = enable_q | rd_wait_q;
  assign capture        = rd_wait_q && (state_q == ST_READ_RESULT);
  assign accept         = (state_q == ST_SEND_PIXEL) && pixel_ready_q && i_pixel_valid && !i_end_frame;
  assign result_end_any = i_result_end | end_seen_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_frame_start) state_d = ST_IP_RESET;
      end
      ST_IP_RESET: begin
        state_d = ST_SEND_PIXEL;
      end
      ST_SEND_PIXEL: begin
        if (i_end_frame)  state_d = ST_READ_RESULT;
        else if (accept)  state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (i_end_frame)                state_d = ST_READ_RESULT;
        else if (i_ready_recieve_pixel) state_d = ST_SEND_PIXEL;
        else if (timeout)               state_d = ST_ERROR;
      end
      ST_READ_RESULT: begin
        if (result_end_any && !result_valid_q && !outstanding) state_d = ST_DONE;
        else if (timeout)                                      state_d = ST_ERROR;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (i_frame_start) state_d = ST_IP_RESET;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    pixel_ready_d = (state_d == ST_SEND_PIXEL);
    ip_reset_d    = (state_d == ST_IP_RESET);
    start_d       = accept;
    end_d         = (state_d == ST_WAIT_ACK);
    busy_d        = (state_d != ST_IDLE) && (state_d != ST_ERROR);
    frame_done_d  = (state_d == ST_DONE);
    pixel_d       = accept ? i_pixel : pixel_q;

    // A new read is only launched into an empty buffer and never after the IP has signalled the end.
    enable_d = (state_q == ST_READ_RESULT) && (state_d == ST_READ_RESULT) &&
               !result_valid_q && !outstanding && !result_end_any;
    rd_wait_d = enable_q;

    end_seen_d = end_seen_q;
    if ((state_q == ST_READ_RESULT) && i_result_end) end_seen_d = 1'b1;
    if (state_d != ST_READ_RESULT)                   end_seen_d = 1'b0;

    result_valid_d = result_valid_q;
    result_data_d  = result_data_q;
    count_d        = count_q;
    if (capture) begin
      result_valid_d = 1'b1;
      result_data_d  = i_result_data;
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
    end else if (result_valid_q && i_result_ready) begin
      result_valid_d = 1'b0;
    end
    if (state_d == ST_IP_RESET) begin
      result_valid_d = 1'b0;
      count_d        = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      pixel_ready_q  <= 1'b0;
      ip_reset_q     <= 1'b0;
      start_q        <= 1'b0;
      end_q          <= 1'b0;
      enable_q       <= 1'b0;
      rd_wait_q      <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      end_seen_q     <= 1'b0;
      pixel_q        <= '0;
      result_data_q  <= '0;
      count_q        <= 16'd0;
    end else begin
      state_q        <= state_d;
      pixel_ready_q  <= pixel_ready_d;
      ip_reset_q     <= ip_reset_d;
      start_q        <= start_d;
      end_q          <= end_d;
      enable_q       <= enable_d;
      rd_wait_q      <= rd_wait_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      end_seen_q     <= end_seen_d;
      pixel_q        <= pixel_d;
      result_data_q  <= result_data_d;
      count_q        <= count_d;
    end
  end

`ifdef FDS_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            error_q, error_d;
  logic            wd_state;

  assign wd_state = (state_q == ST_WAIT_ACK) || (state_q == ST_READ_RESULT);
  // wd_q holds the number of earlier stalled cycles, so the limit fires on the TIMEOUT_CYCLES-th one.
  assign timeout  = wd_state && !capture && (wd_q == WD_LIMIT);

  always_comb begin
    wd_d    = wd_q + 1'b1;
    error_d = (state_d == ST_ERROR);
    if (!wd_state || capture || (state_d != state_q)) wd_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      error_q <= error_d;
    end
  end

  assign o_error = error_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign o_error            = 1'b0;
`endif

  assign o_pixel_ready         = pixel_ready_q;
  assign o_ip_reset            = ip_reset_q;
  assign o_start_recieve_pixel = start_q;
  assign o_pixel               = pixel_q;
  assign o_end_recieve_pixel   = end_q;
  assign o_enable_read_result  = enable_q;
  assign o_result_valid        = result_valid_q;
  assign o_result_data         = result_data_q;
  assign o_busy                = busy_q;
  assign o_frame_done          = frame_done_q;
  assign o_result_count        = count_q;

endmodule

// File: tb/tb_facial_detection_sequencer.sv
// Self-checking bench for facial_detection_sequencer: directed frames plus randomized pixel/result traffic.
// The watchdog section is compiled in only when FDS_TIMEOUT_EN is defined.
module tb_facial_detection_sequencer;

  localparam int PW = 16;
  localparam int DW = 12;
  localparam int TO = 16;

  logic          clk;
  logic          reset_n;
  logic          i_frame_start;
  logic          i_pixel_valid;
  logic [PW-1:0] i_pixel;
  logic          o_pixel_ready;
  logic          o_ip_reset;
  logic          o_start_recieve_pixel;
  logic [PW-1:0] o_pixel;
  logic          o_end_recieve_pixel;
  logic          i_ready_recieve_pixel;
  logic          i_end_frame;
  logic          o_enable_read_result;
  logic [DW-1:0] i_result_data;
  logic          i_result_end;
  logic          o_result_valid;
  logic [DW-1:0] o_result_data;
  logic          i_result_ready;
  logic          o_busy;
  logic          o_frame_done;
  logic          o_error;
  logic [15:0]   o_result_count;

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] res_tab [8];

  facial_detection_sequencer #(
    .PIXEL_WIDTH   (PW),
    .DATA_WIDTH_12 (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .i_frame_start        (i_frame_start),
    .i_pixel_valid        (i_pixel_valid),
    .i_pixel              (i_pixel),
    .o_pixel_ready        (o_pixel_ready),
    .o_ip_reset           (o_ip_reset),
    .o_start_recieve_pixel(o_start_recieve_pixel),
    .o_pixel              (o_pixel),
    .o_end_recieve_pixel  (o_end_recieve_pixel),
    .i_ready_recieve_pixel(i_ready_recieve_pixel),
    .i_end_frame          (i_end_frame),
    .o_enable_read_result (o_enable_read_result),
    .i_result_data        (i_result_data),
    .i_result_end         (i_result_end),
    .o_result_valid       (o_result_valid),
    .o_result_data        (o_result_data),
    .i_result_ready       (i_result_ready),
    .o_busy               (o_busy),
    .o_frame_done         (o_frame_done),
    .o_error              (o_error),
    .o_result_count       (o_result_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      o_busy, 0);
    check({tag, "_pxrdy"},     o_pixel_ready, 0);
    check({tag, "_ipreset"},   o_ip_reset, 0);
    check({tag, "_start"},     o_start_recieve_pixel, 0);
    check({tag, "_end"},       o_end_recieve_pixel, 0);
    check({tag, "_pixel"},     o_pixel, 0);
    check({tag, "_enable"},    o_enable_read_result, 0);
    check({tag, "_rvalid"},    o_result_valid, 0);
    check({tag, "_rdata"},     o_result_data, 0);
    check({tag, "_done"},      o_frame_done, 0);
    check({tag, "_error"},     o_error, 0);
    check({tag, "_count"},     o_result_count, 0);
  endtask

  // Host offers one pixel; the IP acknowledges after 'delay' further cycles of o_end_recieve_pixel.
  task automatic send_pixel(input logic [PW-1:0] val, input int delay);
    check("px_ready_before", o_pixel_ready, 1);
    i_pixel       = val;
    i_pixel_valid = 1'b1;
    step();
    i_pixel_valid = 1'b0;
    i_pixel       = PW'($urandom);
    check("start_pulse", o_start_recieve_pixel, 1);
    check("px_latched", o_pixel, val);
    check("end_high", o_end_recieve_pixel, 1);
    check("px_ready_low", o_pixel_ready, 0);
    for (int k = 0; k < delay; k++) begin
      step();
      check("start_once", o_start_recieve_pixel, 0);
      check("end_hold", o_end_recieve_pixel, 1);
      check("px_hold", o_pixel, val);
    end
    i_ready_recieve_pixel = 1'b1;
    step();
    i_ready_recieve_pixel = 1'b0;
    check("end_drop", o_end_recieve_pixel, 0);
    check("px_ready_back", o_pixel_ready, 1);
    $display("pixel %h accepted, ack after %0d cycles", val, delay + 1);
  endtask

  // Acts as the IP (answers each read enable one cycle later) and as the host (holds ready low).
  task automatic read_results(input int nres, input int hold_max, input bit rand_hold);
    int issued = 0;
    int got = 0;
    int hold = 0;
    int hold_target;
    int budget = 0;
    bit drive = 1'b0;
    bit done = 1'b0;
    logic [DW-1:0] exp_d;
    hold_target = rand_hold ? int'($urandom_range(hold_max, 0)) : hold_max;
    while (!done && budget < 400) begin
      if (o_frame_done) begin
        done = 1'b1;
      end else begin
        i_result_data = drive ? res_tab[issued - 1] : DW'($urandom);
        drive = o_enable_read_result;
        if (o_enable_read_result) issued++;
        i_result_end = (issued >= nres);
        check("no_enable_while_valid", o_enable_read_result & o_result_valid, 0);
        exp_d = (got < nres) ? res_tab[got] : ~res_tab[0];
        if (o_result_valid) begin
          if (hold < hold_target) begin
            i_result_ready = 1'b0;
            check("rdata_hold", o_result_data, exp_d);
            hold++;
          end else begin
            i_result_ready = 1'b1;
            check("rdata", o_result_data, exp_d);
            $display("result %0d = %h delivered after %0d stalled cycles", got, o_result_data, hold);
            got++;
            hold = 0;
            hold_target = rand_hold ? int'($urandom_range(hold_max, 0)) : hold_max;
          end
        end else begin
          i_result_ready = 1'b0;
        end
        step();
        budget++;
      end
    end
    check("frame_done_seen", done, 1);
    check("reads_issued", issued, nres);
    check("results_delivered", got, nres);
    check("result_count", o_result_count, nres);
    check("busy_in_done", o_busy, 1);
    i_result_end   = 1'b0;
    i_result_ready = 1'b0;
    step();
    check("frame_done_1cyc", o_frame_done, 0);
    check("idle_not_busy", o_busy, 0);
    $display("frame finished: %0d results", got);
  endtask

  initial begin
    int npx;
    int nres;
    int wait_cnt;
    logic [PW-1:0] last_px;

    reset_n = 1'b0;
    i_frame_start = 1'b0;
    i_pixel_valid = 1'b0;
    i_pixel = '0;
    i_ready_recieve_pixel = 1'b0;
    i_end_frame = 1'b0;
    i_result_data = '0;
    i_result_end = 1'b0;
    i_result_ready = 1'b0;

    // Reset state
    step();
    step();
    check_all_zero("reset");
    reset_n = 1'b1;
    step();
    check("idle_after_reset", o_busy, 0);

    // Frame 1: directed
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    check("ip_reset_pulse", o_ip_reset, 1);
    check("busy_ip_reset", o_busy, 1);
    check("px_ready_in_ip_reset", o_pixel_ready, 0);
    step();
    check("ip_reset_1cyc", o_ip_reset, 0);
    check("px_ready_send", o_pixel_ready, 1);
    check("busy_send", o_busy, 1);
    $display("frame 1 started");

    send_pixel(16'h00A5, 4);

    i_pixel       = 16'hBEEF;
    i_pixel_valid = 1'b1;
    i_end_frame   = 1'b1;
    step();
    i_pixel_valid = 1'b0;
    i_end_frame   = 1'b0;
    check("endframe_no_start", o_start_recieve_pixel, 0);
    check("endframe_px_unchanged", o_pixel, 16'h00A5);
    check("endframe_px_ready_low", o_pixel_ready, 0);
    check("endframe_no_end", o_end_recieve_pixel, 0);
    check("endframe_busy", o_busy, 1);
    $display("end_frame beat pixel in SEND_PIXEL");

    res_tab[0] = 12'h010;
    res_tab[1] = 12'h020;
    res_tab[2] = 12'h030;
    read_results(3, 4, 1'b0);

    // Frame 2: randomized
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    check("f2_ip_reset", o_ip_reset, 1);
    check("f2_count_cleared", o_result_count, 0);
    step();
    npx = $urandom_range(6, 3);
    for (int p = 0; p < npx; p++) begin
      if ($urandom_range(1, 0) == 1) begin
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
        check("start_ignored_send", o_ip_reset, 0);
        check("px_ready_idle_cycle", o_pixel_ready, 1);
      end
      send_pixel(PW'($urandom), $urandom_range(6, 0));
    end
    last_px       = PW'($urandom);
    i_pixel       = last_px;
    i_pixel_valid = 1'b1;
    step();
    i_pixel_valid = 1'b0;
    check("f2_last_start", o_start_recieve_pixel, 1);
    i_end_frame = 1'b1;
    step();
    i_end_frame = 1'b0;
    check("endframe_wait_end_low", o_end_recieve_pixel, 0);
    check("endframe_wait_px_ready", o_pixel_ready, 0);
    check("endframe_wait_px", o_pixel, last_px);
    $display("end_frame during WAIT_ACK after pixel %h", last_px);
    nres = $urandom_range(5, 1);
    for (int r = 0; r < nres; r++) res_tab[r] = DW'($urandom);
    read_results(nres, 5, 1'b1);

    // Frame 3: asynchronous reset while a result is pending
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    step();
    i_end_frame = 1'b1;
    step();
    i_end_frame   = 1'b0;
    i_result_data = 12'h5A5;
    wait_cnt = 0;
    while (!o_result_valid && wait_cnt < 20) begin
      step();
      wait_cnt++;
    end
    check("f3_valid_before_reset", o_result_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    $display("reset_n asserted mid READ_RESULT");
    @(negedge clk);
    step();
    reset_n = 1'b1;
    step();
    check("post_reset_idle", o_busy, 0);
    check("post_reset_no_ipreset", o_ip_reset, 0);
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    check("post_reset_operational", o_ip_reset, 1);
    step();
    check("post_reset_px_ready", o_pixel_ready, 1);

    i_pixel       = 16'h1234;
    i_pixel_valid = 1'b1;
    step();
    i_pixel_valid = 1'b0;
`ifdef FDS_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      check("wd_no_early_error", o_error, 0);
      check("wd_end_high", o_end_recieve_pixel, 1);
      step();
    end
    check("wd_error_set", o_error, 1);
    check("wd_error_not_busy", o_busy, 0);
    check("wd_error_end_low", o_end_recieve_pixel, 0);
    step();
    step();
    check("wd_error_sticky", o_error, 1);
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    check("wd_error_cleared", o_error, 0);
    check("wd_restart_ipreset", o_ip_reset, 1);
    $display("watchdog tripped after %0d WAIT_ACK cycles and recovered", TO);
`else
    for (int k = 0; k < TO + 4; k++) begin
      check("no_wd_error", o_error, 0);
      check("no_wd_end_high", o_end_recieve_pixel, 1);
      step();
    end
    i_ready_recieve_pixel = 1'b1;
    step();
    i_ready_recieve_pixel = 1'b0;
    check("no_wd_resume", o_pixel_ready, 1);
    $display("long WAIT_ACK without watchdog resumed normally");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
